seg_display_mux: RTL
====================

# seg_display_mux

Parametrised multiplexed seven-segment driver: the next generation of the 8-digit hex display driver, generalised to any digit count and extended with per-digit enable, decimal points, brightness PWM and tear-free frame latching. It sits between core logic (status words, counters, FFT readouts) and the board's common-anode display pins. It time-multiplexes one digit at a time and owns all display refresh timing.

## Interface
- DIGITS, 8, number of digits driven (1..16)
- DWELL, 8192, clk cycles each digit is selected (must be ≥ 2^BRIGHT_BITS)
- BRIGHT_BITS, 4, width of the brightness control
- clk  input  1  system clock; the only clock
- reset_n  input  1  asynchronous, active-low reset
- data  input  4*DIGITS  hex nibbles, digit DIGITS-1 in the top nibble
- dp  input  DIGITS  decimal point request per digit, 1 = lit
- digit_en  input  DIGITS  per-digit enable, 0 = digit forced dark
- brightness  input  BRIGHT_BITS  0 = dark, all-ones = full on
- seg  output  7  segments g..a, active-low
- dp_out  output  1  decimal-point segment, active-low
- strobe  output  DIGITS  digit anodes, active-low, one-hot-low when lit
- frame_start  output  1  one-cycle pulse when a new frame begins

## Operation
- State: dwell counter (0..DWELL-1), digit index (DIGITS-1 down to 0), free-running PWM counter (BRIGHT_BITS wide), shadow copies of data/dp/digit_en.
- Scan order: digit index starts at DIGITS-1 (leftmost, strobe[DIGITS-1]) and decrements. When the dwell counter reaches DWELL-1, it wraps to 0 and the index decrements. From 0, the index wraps to DIGITS-1.
- Frame boundary: the cycle the index wraps from 0 to DIGITS-1. In that cycle, shadows capture data, dp and digit_en, and frame_start pulses. Inputs may change at any time; only frame-boundary values are displayed, so there is no tearing.
- Lit condition for the current digit i: shadow digit_en[i] = 1 AND (brightness = all-ones OR pwm_cnt < brightness). When lit, strobe = ~(1 << i); otherwise all ones.
- seg = hex glyph of shadow nibble i; dp_out = ~shadow dp[i]. Both are forced to all ones (dark) when the digit is not lit.
- Blanking gap: strobe is all ones on the first cycle of every dwell (dwell counter = 0). This prevents ghosting while seg changes.
- Glyphs: the standard 0-F active-low set (0 = 7'b100_0000, 8 = 7'b000_0000, F = 7'b000_1110).

## Timing
- All outputs are registered. They reflect counter state with one cycle of latency.
- Reset (reset_n low, asynchronous): seg = 7'h7F, dp_out = 1, strobe = all ones, frame_start = 0. Dwell and PWM counters = 0, index = DIGITS-1, shadows = 0.
- First frame_start occurs DIGITS*DWELL cycles after reset release, plus 1 for the output register. Shadows hold zero until then, and with digit_en shadow = 0 the display stays dark.
- Reset asserted mid-frame: outputs go dark immediately. The scan restarts at digit DIGITS-1, and the frame_start cadence restarts from reset release.
- brightness change: takes effect on the next PWM compare, with no frame alignment.
- Frame period = DIGITS*DWELL cycles, with exactly one frame_start per period.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. Digit i is dark when its shadow nibble and all higher shadow nibbles are 0. Digit 0 is never blanked by this rule, and a lit dp on digit i keeps digit i visible. Evaluated on shadow values.
- SEG_LZB_EN undefined: every enabled digit shows its glyph, zeros included. No extra logic is built.

## Structure
- Package seg_pkg: the active-low 16-entry glyph table, SEG_BLANK = 7'h7F, and a digit-index width function (clog2 of DIGITS).
- One sub-module, seg_hex_decode: nibble in, 7-bit active-low glyph out (combinational). Instantiated once on the selected shadow nibble.

## Test plan
- Reset and first frame (DIGITS=4, DWELL=32, BRIGHT_BITS=2, brightness=3, digit_en=4'hF, data=16'h1234): after the first frame_start, strobe cycles 0111 → 1011 → 1101 → 1110 with seg = glyph 1, 2, 3, 4. Each strobe is low for 31 cycles, and a 1-cycle all-ones gap precedes each.
- Tear-free latch: change data to 16'hABCD mid-frame. The current frame still shows 1234, and ABCD appears only after the next frame_start.
- Brightness: with brightness=1, strobe is low for 1 of every 4 cycles. With brightness=0, strobe is always all ones while frame_start still pulses every 128 cycles.
- Enable and dp: with digit_en=4'b1010 and dp=4'b0001, digits 2 and 0 stay dark. Digit 0's dp_out stays 1 because the digit is disabled.
- SEG_LZB_EN: data=16'h0050 shows digits 1 and 0 only ("50"). data=16'h0000 shows a single "0" on digit 0. Without the macro, the same data shows "0050".
- Async reset mid-dwell: pulling reset_n low for 3 cycles while digit 1 is lit gives immediate strobe=all ones and seg=7'h7F. After release, the scan restarts at digit 3.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver:
// the active-low hex glyph table, the blank pattern and a digit-index width helper.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order g..a, active-low; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int unsigned idx_width(input int unsigned digits);
        return (digits <= 32'd1) ? 32'd1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph
);

    // Table lookup of the glyph for the incoming nibble.
    always_comb begin
        o_glyph = SEG_GLYPHS[i_nibble];
    end

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed common-anode seven-segment driver with per-digit enable, decimal
// points, brightness PWM and frame-latched shadows. Optional macro: SEG_LZB_EN.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned DWELL       = 8192,
    parameter int unsigned BRIGHT_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [4*DIGITS-1:0]      data,
    input  logic [DIGITS-1:0]        dp,
    input  logic [DIGITS-1:0]        digit_en,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    output logic [6:0]               seg,
    output logic                     dp_out,
    output logic [DIGITS-1:0]        strobe,
    output logic                     frame_start
);

    localparam int unsigned IW = idx_width(DIGITS);
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IW-1:0] IDX_TOP   = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DWELL_END = DW'(DWELL - 1);

    logic [DW-1:0]          r_dwell;
    logic [IW-1:0]          r_idx;
    logic [BRIGHT_BITS-1:0] r_pwm;
    logic                   r_new_frame;
    logic [4*DIGITS-1:0]    r_sh_data;
    logic [DIGITS-1:0]      r_sh_dp;
    logic [DIGITS-1:0]      r_sh_en;
    logic [6:0]             r_seg;
    logic                   r_dp_out;
    logic [DIGITS-1:0]      r_strobe;
    logic                   r_frame_start;

    logic                   w_dwell_end;
    logic                   w_wrap;
    logic [3:0]             w_nibble;
    logic [6:0]             w_glyph;
    logic                   w_bright_on;
    logic                   w_lzb_blank;
    logic                   w_lit;
    logic [6:0]             w_seg_nxt;
    logic                   w_dp_nxt;
    logic [DIGITS-1:0]      w_strobe_nxt;

    assign w_dwell_end = (r_dwell == DWELL_END);
    assign w_wrap      = w_dwell_end && (r_idx == IW'(0));

    // Dwell, scan index and PWM counters; r_new_frame marks the first cycle of a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell     <= DW'(0);
            r_idx       <= IDX_TOP;
            r_pwm       <= BRIGHT_BITS'(0);
            r_new_frame <= 1'b0;
        end else begin
            r_pwm       <= r_pwm + BRIGHT_BITS'(1);
            r_new_frame <= w_wrap;
            if (w_dwell_end) begin
                r_dwell <= DW'(0);
                r_idx   <= (r_idx == IW'(0)) ? IDX_TOP : r_idx - IW'(1);
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    // Shadow registers only move on the frame boundary so a frame never tears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_data <= '0;
            r_sh_dp   <= '0;
            r_sh_en   <= '0;
        end else if (w_wrap) begin
            r_sh_data <= data;
            r_sh_dp   <= dp;
            r_sh_en   <= digit_en;
        end else begin
            r_sh_data <= r_sh_data;
            r_sh_dp   <= r_sh_dp;
            r_sh_en   <= r_sh_en;
        end
    end

    assign w_nibble = r_sh_data[4*r_idx +: 4];

    seg_hex_decode u_decode (
        .i_nibble (w_nibble),
        .o_glyph  (w_glyph)
    );

`ifdef SEG_LZB_EN
    logic [DIGITS-1:0] w_zero_run;

    // w_zero_run[i]: shadow nibble i and every nibble above it are zero.
    always_comb begin
        logic v_run;
        v_run      = 1'b1;
        w_zero_run = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            v_run         = v_run && (r_sh_data[4*i +: 4] == 4'h0);
            w_zero_run[i] = v_run;
        end
    end

    assign w_lzb_blank = (r_idx != IW'(0)) && w_zero_run[r_idx] && !r_sh_dp[r_idx];
`else
    assign w_lzb_blank = 1'b0;
`endif

    assign w_bright_on = (&brightness) || (r_pwm < brightness);
    assign w_lit       = r_sh_en[r_idx] && w_bright_on && !w_lzb_blank;

    // Next output values; the anode stays off on the first cycle of every dwell.
    always_comb begin
        w_seg_nxt    = SEG_BLANK;
        w_dp_nxt     = 1'b1;
        w_strobe_nxt = {DIGITS{1'b1}};
        if (w_lit) begin
            w_seg_nxt = w_glyph;
            w_dp_nxt  = ~r_sh_dp[r_idx];
            if (r_dwell != DW'(0)) begin
                w_strobe_nxt = ~(DIGITS'(1) << r_idx);
            end else begin
                w_strobe_nxt = {DIGITS{1'b1}};
            end
        end else begin
            w_seg_nxt    = SEG_BLANK;
            w_dp_nxt     = 1'b1;
            w_strobe_nxt = {DIGITS{1'b1}};
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg         <= SEG_BLANK;
            r_dp_out      <= 1'b1;
            r_strobe      <= {DIGITS{1'b1}};
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_nxt;
            r_dp_out      <= w_dp_nxt;
            r_strobe      <= w_strobe_nxt;
            r_frame_start <= r_new_frame;
        end
    end

    assign seg         = r_seg;
    assign dp_out      = r_dp_out;
    assign strobe      = r_strobe;
    assign frame_start = r_frame_start;

endmodule
